if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage of the miniLA five-stage pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives a synchronous-read instruction ROM (1-cycle read latency).
- Produces pc / inst / pc+4 / valid for IF/ID.
- Handles hazard-unit stalls (output hold with instruction capture) and branch redirects (in-flight fetch kill).

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset release.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clk.
- stall  input  1  hazard unit: downstream not accepting; hold fetch and outputs.
- br_taken  input  1  redirect request from EX (taken branch/jump).
- br_target  input  32  redirect byte address; bits [1:0] ignored (forced 00).
- irom_addr  output  32  byte address to instruction ROM (combinational = pc_reg).
- irom_rdata  input  32  ROM data for the address presented on the previous cycle.
- if_pc  output  32  PC of the delivered instruction.
- if_inst  output  32  delivered instruction word.
- if_pc4  output  32  if_pc + 4.
- if_valid  output  1  delivered instruction is real (not a bubble).

Behaviour:
- State:
  - pc_reg[31:0]: next address to fetch.
  - f_pc[31:0], f_valid: address and validity of the fetch whose data is on irom_rdata.
  - hold_inst[31:0], hold_valid: captured instruction while stalled.
- Reset (rst=0 at edge; overrides stall and br_taken):
  - pc_reg<=RESET_PC; f_pc<=0; f_valid<=0; hold_inst<=0; hold_valid<=0.
  - Outputs during and after reset until the first fetch: if_valid=0, if_pc=0, if_inst=0, if_pc4=0.
  - Reset asserted mid-operation discards all in-flight and held state on that edge.
- irom_addr = pc_reg at all times; the ROM reads every cycle.
- Output mux (combinational):
  - if_inst = hold_valid ? hold_inst : irom_rdata.
  - if_pc = f_pc; if_pc4 = f_pc + 32'd4.
  - When f_valid=0, if_inst, if_pc and if_pc4 are all forced to 0.
- Priority per edge: reset > br_taken > stall > normal advance.
- Normal advance (br_taken=0, stall=0):
  - f_pc<=pc_reg; f_valid<=1; pc_reg<=pc_reg+4; hold_valid<=0.
  - Latency: address presented in cycle N; instruction valid at outputs in cycle N+1.
  - Sustained throughput is 1 instruction/cycle.
- Stall (stall=1, br_taken=0):
  - pc_reg, f_pc and f_valid hold.
  - If hold_valid=0 and f_valid=1: hold_inst<=irom_rdata, hold_valid<=1. This is a first-stall-cycle capture, needed because the ROM output then changes to mem[pc_reg].
  - If already holding, hold_inst is unchanged.
  - Outputs remain bit-identical for the whole stall.
  - On the edge where stall deasserts (normal advance), hold_valid<=0 and the held instruction is consumed.
- Redirect (br_taken=1, regardless of stall):
  - pc_reg<={br_target[31:2],2'b00}; f_valid<=0; hold_valid<=0.
  - The next cycle shows a bubble (if_valid=0); the target instruction appears valid one cycle after that, provided no stall.
  - Redirect with stall=1: bubble persists until stall clears, then fetch resumes at the target.
  - Back-to-back redirects: the last one wins; each kills the in-flight fetch.
- Arithmetic: all +4 is modulo 2^32; pc_reg 32'hFFFF_FFFC advances to 32'h0000_0000; if_pc4 of 32'hFFFF_FFFC is 0.
- No combinational path from stall/br_taken to if_* outputs; irom_addr depends only on pc_reg.

Test Plan:
- Reset release with ROM mem[0x1C000000+4k]=k: rst low 3 cycles, then high.
  - Required: if_valid=0 and all outputs 0 during reset; irom_addr=0x1C000000 on the first high cycle.
  - Then on successive cycles: if_pc=0x1C000000/inst=0, 0x1C000004/1, 0x1C000008/2; if_pc4=if_pc+4.
- Stall 3 cycles while if_pc=0x1C000008 is delivered.
  - Required: if_pc=0x1C000008, if_inst=2, if_valid=1 constant for all 3 cycles.
  - After release: next is 0x1C00000C/inst=3, with no skip and no duplicate.
- br_taken=1, br_target=0x1C000103 during streaming.
  - Required: next cycle if_valid=0 with outputs 0.
  - Following cycle if_pc=0x1C000100, if_inst=mem[0x1C000100], if_pc4=0x1C000104.
- br_taken and stall asserted together, stall held 2 more cycles.
  - Required: if_valid=0 throughout the stall; first valid instruction after stall drop is at the target.
- Wrap: redirect to 0xFFFFFFF8.
  - Required: delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC (if_pc4=0x0), then 0x00000000.
- rst asserted for 1 cycle during a stall with hold_valid=1.
  - Required: outputs go 0/invalid after that edge; after release, fetch restarts at 0x1C000000 and the stale held instruction is never emitted.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction ROM port and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline, ROM and hazard unit.
interface if_fetch_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] irom_addr;
  logic [31:0] irom_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;

  modport master (
    input  stall, br_taken, br_target, irom_rdata,
    output irom_addr, if_pc, if_inst, if_pc4, if_valid
  );

  modport slave (
    output stall, br_taken, br_target, irom_rdata,
    input  irom_addr, if_pc, if_inst, if_pc4, if_valid
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, 1-cycle sync ROM read, instruction valid the cycle after its address.
// Stall holds PC and outputs (instruction captured on the first stall cycle); redirect kills the in-flight fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic    clk,
  input  logic    rst,
  if_fetch_if.master bus
);

  logic [31:0] pc_reg;
  logic [31:0] f_pc;
  logic        f_valid;
  logic [31:0] hold_inst;
  logic        hold_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg     <= RESET_PC;
      f_pc       <= 32'd0;
      f_valid    <= 1'b0;
      hold_inst  <= 32'd0;
      hold_valid <= 1'b0;
    end else if (bus.br_taken) begin
      pc_reg     <= {bus.br_target[31:2], 2'b00};
      f_valid    <= 1'b0;
      hold_valid <= 1'b0;
    end else if (bus.stall) begin
      // ROM output moves on to mem[pc_reg] next cycle, so keep the delivered word.
      if (!hold_valid && f_valid) begin
        hold_inst  <= bus.irom_rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      f_pc       <= pc_reg;
      f_valid    <= 1'b1;
      pc_reg     <= pc_reg + 32'd4;
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.irom_addr = pc_reg;
    bus.if_valid  = f_valid;
    bus.if_pc     = 32'd0;
    bus.if_pc4    = 32'd0;
    bus.if_inst   = 32'd0;
    if (f_valid) begin
      bus.if_pc   = f_pc;
      bus.if_pc4  = f_pc + 32'd4;
      bus.if_inst = hold_valid ? hold_inst : bus.irom_rdata;
    end
  end

endmodule
